instruction_cache: RTL and testbench
====================================

// Module: instruction_cache
// PURPOSE
//   Read-only, direct-mapped L1 instruction cache between the pipeline fetch port
//   (ICACHE_* signals of the core) and the 128-bit instruction memory.
//   - Hits return the word in the same cycle with no stall.
//   - Misses stall the core, fetch one 4-word block from memory, then replay as a hit.
// PARAMETERS
//   INDEX_W   3   index bits; number of lines = 2**INDEX_W (8 lines x 4 words = 128 B)
//   TAG_W     25  tag bits; must equal 30-2-INDEX_W
// PORTS
//   clk         in   1    clock, rising edge
//   rst_n       in   1    asynchronous active-low reset
//   proc_read   in   1    core fetch request (ICACHE_ren)
//   proc_write  in   1    core write request (ICACHE_wen); ignored, core ties to 0
//   proc_addr   in   30   word address; [1:0] word offset, [INDEX_W+1:2] index, rest tag
//   proc_wdata  in   32   unused
//   proc_stall  out  1    high while request cannot be served this cycle (ICACHE_stall)
//   proc_rdata  out  32   instruction word (ICACHE_rdata)
//   mem_read    out  1    block read request to memory
//   mem_write   out  1    constant 0
//   mem_addr    out  28   block address = proc_addr[29:2] latched at miss
//   mem_wdata   out  128  constant 0
//   mem_rdata   in   128  block data; word0 = [31:0], word3 = [127:96]
//   mem_ready   in   1    one-cycle pulse; mem_rdata valid in that cycle
// BEHAVIOUR
//   Storage: per line valid bit, TAG_W tag, 128-bit data; all registers, no SRAM macro.
//   hit = proc_read & valid[idx] & (tag[idx]==proc_addr tag field) & state==IDLE.
//   FSM, 2 states, registered:
//     IDLE:     proc_read & !hit -> ALLOC; latch proc_addr[29:2] into mem_addr,
//               set mem_read=1 on the same edge. Otherwise stay.
//     ALLOC:    hold mem_read=1 and mem_addr stable until mem_ready.
//               On mem_ready: write mem_rdata to line, set tag and valid,
//               clear mem_read, return to IDLE.
//   proc_stall (combinational) = (state==IDLE & proc_read & !hit) | state==ALLOC.
//   proc_rdata (combinational) = selected word of indexed line; drives 0 when
//     proc_read=0. Value is only meaningful when proc_stall=0.
//   Miss latency: request cycle + N memory cycles + 1 replay cycle.
//     Stall falls in the cycle after mem_ready.
//   proc_read=0: no lookup, no stall, no state change.
//   proc_write is ignored: no stall, no array change.
//   Core holds proc_addr while stalled. The fill always uses the latched mem_addr,
//     never the live proc_addr.
//   mem_ready while in IDLE is ignored (no array write).
//   Replacement: the indexed line is overwritten unconditionally. Nothing is dirty;
//     there is no writeback.
//   Reset (asynchronous, any state, including mid-fill):
//     state=IDLE, all valid=0, mem_read=0, mem_addr=0.
//     Tags and data need not be reset.
//     A memory response arriving after reset is ignored.
//   Outputs at reset: proc_stall=0 (proc_read=0), proc_rdata=0, mem_read=0,
//     mem_write=0, mem_addr=0, mem_wdata=0.
// TESTING
//   1 Cold miss: reset, proc_read=1, addr=30'h0000_0005.
//     -> stall=1 same cycle; mem_read=1 next cycle with mem_addr=28'h1.
//     Memory returns 128'h4444_4444_3333_3333_2222_2222_1111_1111 after 3 cycles.
//     -> stall=0 the cycle after mem_ready; proc_rdata=32'h2222_2222.
//   2 Hit sequence: after test 1, addrs 4,6,7 on consecutive cycles.
//     -> stall=0 on each; rdata 1111_1111, 3333_3333, 4444_4444; mem_read stays 0.
//   3 Conflict: read addr 30'h0000_0025 (same index 1, new tag).
//     -> miss, refill. Then re-read addr 5 -> miss again (direct-mapped eviction).
//   4 proc_read=0 with random addr, and proc_write=1 with proc_read=0.
//     -> stall=0, mem_read=0, no state change.
//   5 Reset mid-fill: assert rst_n=0 while in ALLOC.
//     -> mem_read=0 immediately; a later mem_ready is ignored;
//     next read of the same addr misses.
//   6 Random stream of 2000 fetches vs. a reference memory model.
//     -> every unstalled rdata matches; mem_read never drops before mem_ready.

Source files
------------

// File: rtl/instruction_cache.sv
`default_nettype none
// ============================================================================
// Module      : instruction_cache
// Description : Read-only, direct-mapped L1 instruction cache sitting between
//               the core fetch port and a 128-bit instruction memory.
//               Hits return the addressed word in the request cycle with no
//               stall. A miss stalls the core, fetches one 4-word block,
//               fills the indexed line, and the request then replays as a hit.
//
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   proc_read     core fetch request
//   proc_write    core write request, ignored (instruction side is read-only)
//   proc_addr     30-bit word address: [1:0] word, [INDEX_W+1:2] index, rest tag
//   proc_wdata    unused
//   proc_stall    request cannot be served this cycle
//   proc_rdata    addressed instruction word, 0 when proc_read is low
//   mem_read      block read request, held until mem_ready
//   mem_write     tied 0
//   mem_addr      block address latched at the miss
//   mem_wdata     tied 0
//   mem_rdata     block data, word0 in [31:0]
//   mem_ready     single-cycle pulse, mem_rdata valid in that cycle
//
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_cache #(
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 25
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic         proc_stall,
    output logic [31:0]  proc_rdata,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);

    localparam int c_LINES = 2 ** INDEX_W;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ALLOC = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Storage: valid bits are reset, tags and data are not (valid gates them).
    // ------------------------------------------------------------------------
    logic [c_LINES-1:0]     r_valid;
    logic [TAG_W-1:0]       r_tag  [c_LINES];
    logic [3:0][31:0]       r_data [c_LINES];

    state_t                 r_state;
    logic                   r_mem_read;
    logic [27:0]            r_mem_addr;

    // ------------------------------------------------------------------------
    // Address decode of the live request
    // ------------------------------------------------------------------------
    logic [1:0]             w_offset;
    logic [INDEX_W-1:0]     w_index;
    logic [TAG_W-1:0]       w_tag;
    logic                   w_hit;
    logic                   w_miss;

    assign w_offset = proc_addr[1:0];
    assign w_index  = proc_addr[INDEX_W+1:2];
    assign w_tag    = proc_addr[29:INDEX_W+2];

    assign w_hit  = proc_read && r_valid[w_index] && (r_tag[w_index] == w_tag)
                 && (r_state == S_IDLE);
    assign w_miss = proc_read && !w_hit && (r_state == S_IDLE);

    // ------------------------------------------------------------------------
    // Fill path: always addressed by the latched block address so that a core
    // which changed proc_addr mid-miss cannot corrupt a different line.
    // ------------------------------------------------------------------------
    logic                   w_fill;
    logic [INDEX_W-1:0]     w_fill_index;
    logic [TAG_W-1:0]       w_fill_tag;

    assign w_fill       = (r_state == S_ALLOC) && mem_ready;
    assign w_fill_index = r_mem_addr[INDEX_W-1:0];
    assign w_fill_tag   = r_mem_addr[27:INDEX_W];

    // ------------------------------------------------------------------------
    // Miss-handling FSM with registered memory request
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_mem_read <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_state    <= S_ALLOC;
                        r_mem_read <= 1'b1;
                        r_mem_addr <= proc_addr[29:2];
                    end
                end
                S_ALLOC: begin
                    if (mem_ready) begin
                        r_state    <= S_IDLE;
                        r_mem_read <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_mem_read <= 1'b0;
                end
            endcase
        end
    end

    // Valid bits: a response arriving in IDLE (e.g. after a reset that
    // aborted a fill) never reaches here because w_fill requires ALLOC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[w_fill_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_fill_index]  <= w_fill_tag;
            r_data[w_fill_index] <= mem_rdata;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign proc_stall = w_miss || (r_state == S_ALLOC);
    assign proc_rdata = proc_read ? r_data[w_index][w_offset] : 32'd0;

    assign mem_read   = r_mem_read;
    assign mem_addr   = r_mem_addr;
    assign mem_write  = 1'b0;
    assign mem_wdata  = '0;

    // Write-side inputs are intentionally unconnected to any logic.
    logic w_unused;
    assign w_unused = &{1'b0, proc_write, proc_wdata};

endmodule
`default_nettype wire

// File: tb/tb_instruction_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_cache
// Description : Directed and random self-checking bench for instruction_cache.
//               A reference memory supplies blocks; a small tag/valid model
//               predicts hit/miss and the stall length of each fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_cache;

    logic         clk;
    logic         rst_n;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference tag/valid model (8 lines, tag = addr[29:5])
    logic        m_valid [8];
    logic [24:0] m_tag   [8];

    instruction_cache #(.INDEX_W(3), .TAG_W(25)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [127:0] obs,
                               input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference memory: block 1 holds the known test pattern.
    function automatic logic [31:0] word_of(input logic [29:0] waddr);
        logic [31:0] w;
        if (waddr[29:2] == 28'h1)
            w = 32'h1111_1111 * (32'(waddr[1:0]) + 32'd1);
        else
            w = (32'(waddr) * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
        return w;
    endfunction

    function automatic logic [127:0] block_of(input logic [27:0] baddr);
        logic [127:0] b;
        for (int k = 0; k < 4; k++)
            b[k*32 +: 32] = word_of({baddr, 2'(k)});
        return b;
    endfunction

    // Issue one fetch and service memory until the stall clears.
    task automatic fetch(input logic [29:0] addr, input int lat, output int stalls);
        int  wait_cnt;
        logic prev_mr;
        logic prev_rdy;
        stalls   = 0;
        wait_cnt = 0;
        prev_mr  = 1'b0;
        prev_rdy = 1'b0;
        forever begin
            @(negedge clk);
            proc_read  = 1'b1;
            proc_write = 1'b0;
            proc_addr  = addr;
            mem_ready  = 1'b0;
            if (prev_mr && !prev_rdy)
                check_value("mem_read_hold", {127'd0, mem_read}, 128'd1);
            if (mem_read) begin
                wait_cnt++;
                if (wait_cnt == lat) begin
                    check_value("mem_addr", {100'd0, mem_addr}, {100'd0, addr[29:2]});
                    mem_ready = 1'b1;
                    mem_rdata = block_of(mem_addr);
                end
            end
            prev_mr  = mem_read;
            prev_rdy = mem_ready;
            #1;
            if (!proc_stall) begin
                check_value("rdata", {96'd0, proc_rdata}, {96'd0, word_of(addr)});
                break;
            end
            stalls++;
            if (stalls > 50) begin
                check_value("stall_timeout", 128'd1, 128'd0);
                break;
            end
        end
    endtask

    // Fetch and compare stall length with the model's hit/miss prediction.
    task automatic fetch_check(input string tag, input logic [29:0] addr, input int lat);
        int   stalls;
        logic miss;
        miss = !(m_valid[addr[4:2]] && m_tag[addr[4:2]] == addr[29:5]);
        fetch(addr, lat, stalls);
        check_value(tag, 128'(stalls), miss ? 128'(lat + 1) : 128'd0);
        m_valid[addr[4:2]] = 1'b1;
        m_tag[addr[4:2]]   = addr[29:5];
    endtask

    task automatic clear_model();
        for (int k = 0; k < 8; k++) begin
            m_valid[k] = 1'b0;
            m_tag[k]   = '0;
        end
    endtask

    initial begin
        int stalls;
        logic [29:0] ra;
        rst_n      = 1'b0;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;
        mem_rdata  = '0;
        mem_ready  = 1'b0;
        clear_model();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_value("rst_stall",  {127'd0, proc_stall}, 128'd0);
        check_value("rst_rdata",  {96'd0, proc_rdata},  128'd0);
        check_value("rst_mread",  {127'd0, mem_read},   128'd0);
        check_value("rst_mwrite", {127'd0, mem_write},  128'd0);
        check_value("rst_maddr",  {100'd0, mem_addr},   128'd0);
        check_value("rst_mwdata", mem_wdata,            128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: cold miss, explicit first-cycle checks then the full fetch
        @(negedge clk);
        proc_read = 1'b1;
        proc_addr = 30'h5;
        #1;
        check_value("t1_stall_now", {127'd0, proc_stall}, 128'd1);
        check_value("t1_mread_now", {127'd0, mem_read},   128'd0);
        @(negedge clk);
        #1;
        check_value("t1_mread_next", {127'd0, mem_read}, 128'd1);
        check_value("t1_maddr_next", {100'd0, mem_addr}, 128'h1);
        // one mem_read cycle already consumed, so 2 more to reach 3
        fetch(30'h5, 2, stalls);
        check_value("t1_stalls", 128'(stalls), 128'd2);
        check_value("t1_rdata", {96'd0, proc_rdata}, 128'h2222_2222);
        m_valid[1] = 1'b1;
        m_tag[1]   = '0;

        // 2: hits on consecutive cycles
        fetch_check("t2_hit4", 30'h4, 3);
        check_value("t2_mread4", {127'd0, mem_read}, 128'd0);
        fetch_check("t2_hit6", 30'h6, 3);
        fetch_check("t2_hit7", 30'h7, 3);
        check_value("t2_rdata7", {96'd0, proc_rdata}, 128'h4444_4444);
        check_value("t2_mread7", {127'd0, mem_read}, 128'd0);

        // 3: conflict eviction on index 1
        fetch_check("t3_miss25", 30'h25, 3);
        fetch_check("t3_miss5",  30'h5, 2);
        fetch_check("t3_miss25b", 30'h25, 1);
        fetch_check("t3_hit25",  30'h24, 1);

        // 4: idle / write cycles, plus stray mem_ready in IDLE
        @(negedge clk);
        proc_read = 1'b0;
        proc_addr = 30'h2ABC_DEF1;
        #1;
        check_value("t4_noread_stall", {127'd0, proc_stall}, 128'd0);
        check_value("t4_noread_rdata", {96'd0, proc_rdata}, 128'd0);
        check_value("t4_noread_mread", {127'd0, mem_read}, 128'd0);
        @(negedge clk);
        proc_write = 1'b1;
        proc_addr  = 30'h5;
        proc_wdata = 32'hDEAD_BEEF;
        mem_ready  = 1'b1;
        mem_rdata  = {4{32'hBAD0_BAD0}};
        #1;
        check_value("t4_write_stall", {127'd0, proc_stall}, 128'd0);
        check_value("t4_write_mread", {127'd0, mem_read}, 128'd0);
        @(negedge clk);
        proc_write = 1'b0;
        mem_ready  = 1'b0;
        fetch_check("t4_hit25", 30'h27, 2);

        // 5: reset in the middle of a fill
        @(negedge clk);
        proc_read = 1'b1;
        proc_addr = 30'h9;
        #1;
        check_value("t5_stall", {127'd0, proc_stall}, 128'd1);
        @(negedge clk);
        #1;
        check_value("t5_alloc_mread", {127'd0, mem_read}, 128'd1);
        rst_n     = 1'b0;
        proc_read = 1'b0;
        #1;
        check_value("t5_rst_mread", {127'd0, mem_read},   128'd0);
        check_value("t5_rst_maddr", {100'd0, mem_addr},   128'd0);
        check_value("t5_rst_stall", {127'd0, proc_stall}, 128'd0);
        @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = {4{32'hBAD1_BAD1}};
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check_value("t5_late_mread", {127'd0, mem_read}, 128'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        clear_model();
        fetch_check("t5_remiss9", 30'h9, 2);
        fetch_check("t5_remiss5", 30'h5, 1);

        // 6: random fetch stream against the reference model
        for (int n = 0; n < 2000; n++) begin
            ra = 30'($urandom_range(0, 127));
            if ($urandom_range(0, 7) == 0)
                ra[29] = 1'b1;
            fetch_check("t6_stalls", ra, int'($urandom_range(1, 4)));
        end

        check_value("end_mwrite", {127'd0, mem_write}, 128'd0);
        check_value("end_mwdata", mem_wdata, 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
